instruction_fetch_decode: RTL and testbench

Front-end stage that feeds instruction_execution. It holds the program counter and fetches one 32-bit instruction word per turn from the instruction memory over a req/ack handshake. It splits the word into type/opc/rs/rt/rd/shamt/funct/imm/iindex, presents the result to the execute stage, and waits for exec_done before loading the execute stage's nextpc and fetching again. Execution is strictly sequential, one instruction in flight.

---
 rtl/instruction_fetch_decode.sv | 152 +++++++++++++++
 tb/tb_instruction_fetch_decode.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_decode.sv
// Sequential fetch/decode front end: fetches one word per turn over req/ack,
// presents the decoded fields, and waits for exec_done before refetching.
module instruction_fetch_decode #(
  parameter int unsigned PC_WIDTH  = 8,
  parameter int unsigned RESET_PC  = 0,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 imem_req,
  output logic [PC_WIDTH-1:0]  imem_addr,
  input  logic                 imem_ack,
  input  logic [31:0]          imem_rdata,
  input  logic [PC_WIDTH-1:0]  nextpc,
  input  logic                 exec_done,
  output logic [PC_WIDTH-1:0]  pc,
  output logic                 instr_valid,
  output logic [1:0]           instr_type,
  output logic [5:0]           opc,
  output logic [4:0]           rs,
  output logic [4:0]           rt,
  output logic [4:0]           rd,
  output logic [4:0]           shamt,
  output logic [5:0]           funct,
  output logic [15:0]          imm,
  output logic [25:0]          iindex,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] issue_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_ISSUE  = 3'd3,
    S_HALT   = 3'd4
  } state_e;

  localparam logic [1:0] T_I    = 2'b00;
  localparam logic [1:0] T_R    = 2'b01;
  localparam logic [1:0] T_J    = 2'b10;
  localparam logic [1:0] T_HALT = 2'b11;

  state_e                 state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [31:0]            ir_q, ir_d;
  logic [31:0]            dec_q, dec_d;
  logic [1:0]             type_q, type_d;
  logic                   halted_q, halted_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [1:0]             ir_type;
  logic [CNT_WIDTH-1:0]   cnt_inc;

  // Instruction class from the raw opcode held in the instruction register
  always_comb begin
    case (ir_q[31:26])
      6'b000000:           ir_type = T_R;
      6'b000010, 6'b000011: ir_type = T_J;
      6'b111111:           ir_type = T_HALT;
      default:             ir_type = T_I;
    endcase
  end

  assign cnt_inc = (cnt_q == {CNT_WIDTH{1'b1}}) ? cnt_q : cnt_q + CNT_WIDTH'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  if (imem_ack) state_d = S_DECODE;
      S_DECODE: state_d = (ir_type == T_HALT) ? S_HALT : S_ISSUE;
      S_ISSUE:  if (exec_done) state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    case (state_q)
      S_FETCH: imem_req    = 1'b1;
      S_ISSUE: instr_valid = 1'b1;
      S_HALT:  instr_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath next-state: pc, instruction register, presented fields, status
  always_comb begin
    pc_d     = pc_q;
    ir_d     = ir_q;
    dec_d    = dec_q;
    type_d   = type_q;
    halted_d = halted_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_FETCH: if (imem_ack) ir_d = imem_rdata;
      S_DECODE: begin
        dec_d  = ir_q;
        type_d = ir_type;
        if (ir_type == T_HALT) begin
          halted_d = 1'b1;
          cnt_d    = cnt_inc;
        end
      end
      S_ISSUE: if (exec_done) begin
        pc_d  = nextpc;
        cnt_d = cnt_inc;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q     <= PC_WIDTH'(RESET_PC);
      ir_q     <= '0;
      dec_q    <= '0;
      type_q   <= '0;
      halted_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      dec_q    <= dec_d;
      type_q   <= type_d;
      halted_q <= halted_d;
      cnt_q    <= cnt_d;
    end
  end

  assign pc          = pc_q;
  assign imem_addr   = pc_q;
  assign instr_type  = type_q;
  assign opc         = dec_q[31:26];
  assign rs          = dec_q[25:21];
  assign rt          = dec_q[20:16];
  assign rd          = dec_q[15:11];
  assign shamt       = dec_q[10:6];
  assign funct       = dec_q[5:0];
  assign imm         = dec_q[15:0];
  assign iindex      = dec_q[25:0];
  assign halted      = halted_q;
  assign issue_count = cnt_q;

endmodule

// File: tb/tb_instruction_fetch_decode.sv
// Directed bench for instruction_fetch_decode; counter width reduced to 2 so
// issue_count saturation is reached within the halt scenario.
module tb_instruction_fetch_decode;

  localparam int unsigned PW = 8;
  localparam int unsigned CW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          imem_req;
  logic [PW-1:0] imem_addr;
  logic          imem_ack;
  logic [31:0]   imem_rdata;
  logic [PW-1:0] nextpc;
  logic          exec_done;
  logic [PW-1:0] pc;
  logic          instr_valid;
  logic [1:0]    instr_type;
  logic [5:0]    opc;
  logic [4:0]    rs, rt, rd, shamt;
  logic [5:0]    funct;
  logic [15:0]   imm;
  logic [25:0]   iindex;
  logic          halted;
  logic [CW-1:0] issue_count;

  int n_checks = 0;
  int n_fail   = 0;

  instruction_fetch_decode #(.PC_WIDTH(PW), .RESET_PC(0), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .nextpc(nextpc),
    .exec_done(exec_done), .pc(pc), .instr_valid(instr_valid),
    .instr_type(instr_type), .opc(opc), .rs(rs), .rt(rt), .rd(rd),
    .shamt(shamt), .funct(funct), .imm(imm), .iindex(iindex),
    .halted(halted), .issue_count(issue_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; imem_ack = 1'b0; exec_done = 1'b0; nextpc = '0; imem_rdata = '0;
    repeat (3) tick();
    n_checks++;
    if ({imem_req, pc, instr_valid, halted, issue_count} !== {1'b0, 8'h00, 1'b0, 1'b0, 2'd0}) begin
      n_fail++;
      $display("FAIL reset_state: req=%b pc=%h valid=%b halted=%b cnt=%0d, want 0/00/0/0/0",
               imem_req, pc, instr_valid, halted, issue_count);
    end
    n_checks++;
    if ({instr_type, opc, iindex} !== 34'd0) begin
      n_fail++;
      $display("FAIL reset_fields: type=%b opc=%h iindex=%h, want 0", instr_type, opc, iindex);
    end
    rst = 1'b1;
    tick();
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 8'h00) begin
      n_fail++;
      $display("FAIL start_fetch: req=%b addr=%h, want 1/00", imem_req, imem_addr);
    end
  endtask

  task automatic test_addiu();
    imem_rdata = 32'h2422_0005; imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    n_checks++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL addiu_decode_cycle: valid=%b req=%b, want 0/0", instr_valid, imem_req);
    end
    tick();
    n_checks++;
    if ({instr_valid, instr_type, opc, rs, rt, imm} !== {1'b1, 2'b00, 6'h09, 5'd1, 5'd2, 16'h0005}) begin
      n_fail++;
      $display("FAIL addiu_fields: valid=%b type=%b opc=%h rs=%0d rt=%0d imm=%h, want 1/00/09/1/2/0005",
               instr_valid, instr_type, opc, rs, rt, imm);
    end
    exec_done = 1'b1; nextpc = 8'h01;
    tick();
    exec_done = 1'b0;
    n_checks++;
    if ({imem_req, imem_addr, issue_count, instr_valid} !== {1'b1, 8'h01, 2'd1, 1'b0}) begin
      n_fail++;
      $display("FAIL addiu_refetch: req=%b addr=%h cnt=%0d valid=%b, want 1/01/1/0",
               imem_req, imem_addr, issue_count, instr_valid);
    end
  endtask

  task automatic test_wait_states();
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (imem_req !== 1'b1 || imem_addr !== 8'h01) begin
        n_fail++;
        $display("FAIL wait_state_%0d: req=%b addr=%h, want 1/01", i, imem_req, imem_addr);
      end
    end
    exec_done = 1'b1; nextpc = 8'h07;
    tick();
    exec_done = 1'b0;
    n_checks++;
    if (pc !== 8'h01 || imem_req !== 1'b1 || issue_count !== 2'd1) begin
      n_fail++;
      $display("FAIL exec_done_in_fetch: pc=%h req=%b cnt=%0d, want 01/1/1", pc, imem_req, issue_count);
    end
  endtask

  task automatic test_decode_classes();
    logic [31:0] snap;
    imem_rdata = 32'h0043_2020; imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    tick();
    n_checks++;
    if ({instr_valid, instr_type, rs, rt, rd, shamt, funct} !== {1'b1, 2'b01, 5'd2, 5'd3, 5'd4, 5'd0, 6'h20}) begin
      n_fail++;
      $display("FAIL rtype_fields: valid=%b type=%b rs=%0d rt=%0d rd=%0d shamt=%0d funct=%h, want 1/01/2/3/4/0/20",
               instr_valid, instr_type, rs, rt, rd, shamt, funct);
    end
    exec_done = 1'b1; nextpc = 8'h02;
    tick();
    exec_done = 1'b0;
    n_checks++;
    if (imem_addr !== 8'h02 || issue_count !== 2'd2) begin
      n_fail++;
      $display("FAIL rtype_refetch: addr=%h cnt=%0d, want 02/2", imem_addr, issue_count);
    end
    imem_rdata = 32'h0800_0010; imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    tick();
    n_checks++;
    if ({instr_type, opc, iindex} !== {2'b10, 6'h02, 26'h10}) begin
      n_fail++;
      $display("FAIL jtype_fields: type=%b opc=%h iindex=%h, want 10/02/0000010", instr_type, opc, iindex);
    end
    // stall with a stray ack/word that must not disturb the presented fields
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 4; i++) begin
      tick();
      snap = {opc, iindex};
      n_checks++;
      if (instr_valid !== 1'b1 || instr_type !== 2'b10 || snap !== 32'h0800_0010 || pc !== 8'h02) begin
        n_fail++;
        $display("FAIL stall_%0d: valid=%b type=%b word=%h pc=%h, want 1/10/08000010/02",
                 i, instr_valid, instr_type, snap, pc);
      end
    end
    imem_ack = 1'b0;
    exec_done = 1'b1; nextpc = 8'hFF;
    tick();
    exec_done = 1'b0;
    n_checks++;
    if (imem_addr !== 8'hFF || issue_count !== 2'd3 || imem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL jtype_refetch: addr=%h cnt=%0d req=%b, want FF/3/1", imem_addr, issue_count, imem_req);
    end
  endtask

  task automatic test_halt();
    imem_rdata = 32'hFC00_0000; imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    tick();
    n_checks++;
    if ({instr_type, halted, instr_valid, issue_count, pc} !== {2'b11, 1'b1, 1'b1, 2'd3, 8'hFF}) begin
      n_fail++;
      $display("FAIL halt_entry: type=%b halted=%b valid=%b cnt=%0d pc=%h, want 11/1/1/3/FF",
               instr_type, halted, instr_valid, issue_count, pc);
    end
    exec_done = 1'b1; nextpc = 8'h09;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if ({pc, imem_req, halted, issue_count, instr_valid} !== {8'hFF, 1'b0, 1'b1, 2'd3, 1'b1}) begin
        n_fail++;
        $display("FAIL halt_hold_%0d: pc=%h req=%b halted=%b cnt=%0d valid=%b, want FF/0/1/3/1",
                 i, pc, imem_req, halted, issue_count, instr_valid);
      end
    end
    exec_done = 1'b0;
  endtask

  task automatic test_reset_mid_fetch();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 8'h00 || halted !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_exits_halt: req=%b addr=%h halted=%b, want 1/00/0", imem_req, imem_addr, halted);
    end
    imem_rdata = 32'hFC00_0000; imem_ack = 1'b1; rst = 1'b0;
    #1;
    n_checks++;
    if (imem_req !== 1'b0 || issue_count !== 2'd0) begin
      n_fail++;
      $display("FAIL async_reset: req=%b cnt=%0d, want 0/0", imem_req, issue_count);
    end
    tick();
    rst = 1'b1; imem_ack = 1'b0;
    n_checks++;
    if ({imem_req, pc, issue_count, instr_type, opc} !== {1'b0, 8'h00, 2'd0, 2'b00, 6'h00}) begin
      n_fail++;
      $display("FAIL reset_idle: req=%b pc=%h cnt=%0d type=%b opc=%h, want 0/00/0/00/00",
               imem_req, pc, issue_count, instr_type, opc);
    end
    tick();
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 8'h00) begin
      n_fail++;
      $display("FAIL refetch_after_reset: req=%b addr=%h, want 1/00", imem_req, imem_addr);
    end
    imem_rdata = 32'h2422_0005; imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    tick();
    n_checks++;
    if ({instr_valid, instr_type, opc, halted, issue_count} !== {1'b1, 2'b00, 6'h09, 1'b0, 2'd0}) begin
      n_fail++;
      $display("FAIL post_reset_decode: valid=%b type=%b opc=%h halted=%b cnt=%0d, want 1/00/09/0/0",
               instr_valid, instr_type, opc, halted, issue_count);
    end
  endtask

  initial begin
    test_reset();
    test_addiu();
    test_wait_states();
    test_decode_classes();
    test_halt();
    test_reset_mid_fetch();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
